// File: rtl/nf10_output_port_demux_pkg.sv
// Shared definitions for the NetFPGA-10G output port demux: tuser field
// offsets written by the output port lookup, and the demux FSM encoding.
package nf10_output_port_demux_pkg;

  localparam int TUSER_LEN_LSB = 0;
  localparam int TUSER_LEN_W   = 16;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_SRC_W   = 8;
  localparam int TUSER_DST_LSB = 24;
  localparam int TUSER_DST_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } demux_state_e;

endpackage

// File: rtl/nf10_axis_out_reg.sv
// One AXI-Stream output register stage: holds a single beat for one master
// port, drains on tready and accepts a reload in the same cycle.
module nf10_axis_out_reg #(
  parameter int DW = 256,
  parameter int UW = 128
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            load_i,
  input  logic [DW-1:0]   tdata_i,
  input  logic [DW/8-1:0] tstrb_i,
  input  logic [UW-1:0]   tuser_i,
  input  logic            tlast_i,
  input  logic            tready_i,
  output logic            tvalid_o,
  output logic [DW-1:0]   tdata_o,
  output logic [DW/8-1:0] tstrb_o,
  output logic [UW-1:0]   tuser_o,
  output logic            tlast_o
);

  logic            valid_q;
  logic            last_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;
  logic [UW-1:0]   user_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= tlast_i;
    end else if (tready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= tdata_i;
      strb_q <= tstrb_i;
      user_q <= tuser_i;
    end
  end

  assign tvalid_o = valid_q;
  assign tlast_o  = last_q;
  assign tdata_o  = data_q;
  assign tstrb_o  = strb_q;
  assign tuser_o  = user_q;

endmodule

// File: rtl/nf10_output_port_demux.sv
// Output port demux: steers each packet to every port named in the tuser
// destination mask (atomic multicast) and discards packets with no destination.
module nf10_output_port_demux
  import nf10_output_port_demux_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_OUTPUTS      = 8
) (
  input  logic                                            axi_aclk,
  input  logic                                            axi_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]                    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]                  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]                   s_axis_tuser,
  input  logic                                            s_axis_tvalid,
  input  logic                                            s_axis_tlast,
  output logic                                            s_axis_tready,
  output logic [C_NUM_OUTPUTS*C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_NUM_OUTPUTS*C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_NUM_OUTPUTS*C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [C_NUM_OUTPUTS-1:0]                        m_axis_tvalid,
  output logic [C_NUM_OUTPUTS-1:0]                        m_axis_tlast,
  input  logic [C_NUM_OUTPUTS-1:0]                        m_axis_tready,
  output logic [31:0]                                     drop_count
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  demux_state_e             state_q, state_d;
  logic [C_NUM_OUTPUTS-1:0] mask_q, mask_d;
  logic [31:0]              drop_count_q, drop_count_d;

  logic [TUSER_DST_W-1:0]   dst_field;
  logic [C_NUM_OUTPUTS-1:0] live_mask;
  logic [C_NUM_OUTPUTS-1:0] cur_mask;
  logic [C_NUM_OUTPUTS-1:0] can_take;
  logic [C_NUM_OUTPUTS-1:0] load;
  logic                     s_ready;
  logic                     accept;

  // Destination bits beyond the port count are simply not looked at.
  assign dst_field = s_axis_tuser[TUSER_DST_LSB +: TUSER_DST_W];
  assign live_mask = dst_field[C_NUM_OUTPUTS-1:0];

  always_comb begin
    cur_mask = (state_q == ST_IDLE) ? live_mask : mask_q;
    s_ready  = !axi_reset &&
               ((state_q == ST_DROP) || ((cur_mask & ~can_take) == '0));
    accept   = s_axis_tvalid && s_ready;
    load     = (accept && (state_q != ST_DROP)) ? cur_mask : '0;
  end

  assign s_axis_tready = s_ready;
  assign drop_count    = drop_count_q;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    drop_count_d = drop_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (live_mask == '0) drop_count_d = drop_count_q + 32'd1;
          if (!s_axis_tlast) begin
            mask_d  = live_mask;
            state_d = (live_mask != '0) ? ST_FWD : ST_DROP;
          end
        end
      end
      ST_FWD, ST_DROP: begin
        if (accept && s_axis_tlast) begin
          state_d = ST_IDLE;
          mask_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      drop_count_q <= drop_count_d;
    end
  end

  for (genvar gi = 0; gi < C_NUM_OUTPUTS; gi++) begin : g_port
    assign can_take[gi] = !m_axis_tvalid[gi] || m_axis_tready[gi];

    nf10_axis_out_reg #(
      .DW(DW),
      .UW(UW)
    ) u_out (
      .clk      (axi_aclk),
      .srst     (axi_reset),
      .load_i   (load[gi]),
      .tdata_i  (s_axis_tdata),
      .tstrb_i  (s_axis_tstrb),
      .tuser_i  (s_axis_tuser),
      .tlast_i  (s_axis_tlast),
      .tready_i (m_axis_tready[gi]),
      .tvalid_o (m_axis_tvalid[gi]),
      .tdata_o  (m_axis_tdata[gi*DW +: DW]),
      .tstrb_o  (m_axis_tstrb[gi*SW +: SW]),
      .tuser_o  (m_axis_tuser[gi*UW +: UW]),
      .tlast_o  (m_axis_tlast[gi])
    );
  end

endmodule

// File: doc/nf10_output_port_demux.md
NF10_OUTPUT_PORT_DEMUX -- requirements
Module: nf10_output_port_demux

Interface
REQ-001 C_AXIS_DATA_WIDTH, 256, tdata width in bits; tstrb width is C_AXIS_DATA_WIDTH/8.
REQ-002 C_AXIS_TUSER_WIDTH, 128, tuser width; bits [31:24] are the one-hot/multi-hot destination mask.
REQ-003 C_NUM_OUTPUTS, 8, number of master ports; mask bit i selects output i.
REQ-004 axi_aclk  input  1  the single clock; all logic is on its rising edge.
REQ-005 axi_reset  input  1  synchronous, active-high reset.
REQ-006 s_axis_tdata/tstrb/tuser/tvalid/tlast  input  256/32/128/1/1  slave stream, driven by the output port lookup.
REQ-007 s_axis_tready  output  1  slave backpressure.
REQ-008 m_axis_tdata/tstrb/tuser  output  C_NUM_OUTPUTS x 256/32/128, flattened  per-port payload; port i occupies slice i.
REQ-009 m_axis_tvalid/tlast  output  C_NUM_OUTPUTS  per-port valid and last.
REQ-010 m_axis_tready  input  C_NUM_OUTPUTS  per-port ready.
REQ-011 drop_count  output  32  count of packets with an all-zero effective mask.

Function
REQ-012 FSM states: IDLE (expects first beat), FWD (mid-packet forward), DROP (mid-packet discard).
REQ-013 In IDLE, the first beat's tuser[31:24] masked to the low C_NUM_OUTPUTS bits is the effective mask; it is latched into mask_q on acceptance and held until tlast.
REQ-014 Per output i, can_take[i] = !m_axis_tvalid[i] || m_axis_tready[i].
REQ-015 s_axis_tready = AND of can_take[i] over every set bit of the current mask (the live mask in IDLE, mask_q otherwise); s_axis_tready is 1 in DROP and when the effective mask is zero.
REQ-016 A beat is accepted when s_axis_tvalid && s_axis_tready; it loads every selected output register in the same edge (multicast is atomic: all or none).
REQ-017 Latency is 1 cycle from slave acceptance to m_axis_tvalid[i]; tdata, tstrb, tuser and tlast are copied unmodified.
REQ-018 Output register i clears tvalid on m_axis_tready[i] when it is not reloaded; a simultaneous drain and reload keeps tvalid=1 and holds the new beat.
REQ-019 Transitions: IDLE -> FWD on accepting a first beat with nonzero mask and !tlast; IDLE -> DROP on zero mask and !tlast; a single-beat packet stays in IDLE; FWD/DROP -> IDLE on accepting a tlast beat.
REQ-020 drop_count increments by 1 on acceptance of the first beat of a zero-mask packet; it wraps from 0xFFFFFFFF to 0.
REQ-021 Unselected outputs never assert tvalid for the packet; mask bits at or above C_NUM_OUTPUTS are ignored.
REQ-022 Output payload registers hold their value while tvalid=1 and tready=0 (AXI-Stream stability).
REQ-023 A tuser mask change on non-first beats has no effect.

Reset
REQ-024 While axi_reset=1: FSM=IDLE, mask_q=0, all m_axis_tvalid=0, m_axis_tlast=0, drop_count=0, s_axis_tready=0.
REQ-025 Reset mid-packet discards the remainder of the in-flight packet and all held beats; after release the next beat is treated as a first beat.
REQ-026 Payload registers need not be reset; their contents are don't-care while tvalid=0.

Structure
REQ-027 The tuser field offsets (length [15:0], src [23:16], dst [31:24]) and the FSM state encodings belong in the shared nf10 AXIS defines include.
REQ-028 The per-port output register (valid/payload, drain/reload) is one sub-module, nf10_axis_out_reg, instantiated C_NUM_OUTPUTS times in a generate loop.

Verification
REQ-029 A 3-beat packet with dst=0x04 and all tready=1 -> it appears only on port 2, one cycle after each acceptance, with identical data and tlast on beat 3.
REQ-030 A 2-beat packet with dst=0x11 and m_axis_tready[4]=0 for 5 cycles -> s_axis_tready=0 and neither port 0 nor port 4 advances past beat 1; after release both ports receive both beats in lockstep.
REQ-031 A 4-beat packet with dst=0x00, then a 1-beat packet with dst=0x00 -> no m_axis_tvalid asserted, s_axis_tready=1 throughout, drop_count=2.
REQ-032 Back-to-back 1-beat packets to port 1, then port 3, then port 1, with random tready -> each port's output order matches its input order, no loss or duplication.
REQ-033 axi_reset asserted on beat 2 of a 5-beat packet -> next cycle all tvalid=0 and drop_count=0; a following 1-beat packet with dst=0x02 is delivered on port 1.
REQ-034 drop_count preloaded (forced) to 0xFFFFFFFF, then one zero-mask packet -> drop_count=0.
